gesture_sequencer: RTL and testbench

Downstream controller for the debounced gesture pulses from the button/switch front end. It queues gesture commands and plays them back one at a time. For each gesture it ramps per-finger servo pulse-width targets toward open/closed positions at a fixed slew rate, then holds the pose for a dwell time before starting the next gesture. Its outputs feed the servo PWM generators.

---
 rtl/gesture_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_gesture_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gesture_sequencer.sv
// Gesture command queue and servo pose sequencer: pops queued finger masks,
// slews each channel's pulse width toward open/closed at a fixed rate, then dwells.
module gesture_sequencer #(
    parameter int CHANNELS    = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int POS_W       = 11,
    parameter int POS_OPEN    = 1000,
    parameter int POS_CLOSED  = 2000,
    parameter int STEP        = 10,
    parameter int TICK_DIV    = 50000,
    parameter int DWELL_TICKS = 500
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           gesture_in,
    input  logic                          home,
    output logic [CHANNELS*POS_W-1:0]     pos_flat,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DWELL_TICKS > 0) ? $clog2(DWELL_TICKS + 1) : 1;

    localparam logic [TW-1:0]    TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL_TICKS);
    localparam logic [AW:0]      COUNT_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [POS_W-1:0] P_OPEN     = POS_W'(POS_OPEN);
    localparam logic [POS_W-1:0] P_CLOSED   = POS_W'(POS_CLOSED);
    localparam logic [POS_W-1:0] P_STEP     = POS_W'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAMP,
        ST_DWELL
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [TW-1:0]       r_tickCnt;
    logic                w_tick;

    logic [CHANNELS-1:0] r_fifoMem [FIFO_DEPTH];
    logic [AW-1:0]       r_wrPtr;
    logic [AW-1:0]       r_rdPtr;
    logic [AW:0]         r_count;
    logic                r_overflow;
    logic                w_empty;
    logic                w_full;
    logic                w_gestValid;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [CHANNELS-1:0] w_head;

    logic [POS_W-1:0]    r_pos     [CHANNELS];
    logic [POS_W-1:0]    r_target  [CHANNELS];
    logic [POS_W-1:0]    w_posNext [CHANNELS];
    logic [CHANNELS-1:0] w_reached;
    logic                w_allReached;
    logic [DW-1:0]       r_dwellCnt;

    assign w_tick = (r_tickCnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tickCnt <= '0;
        end else if (w_tick) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + 1'b1;
        end
    end

    // home outranks both queue operations; a pop frees a slot for a same-cycle push
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == COUNT_FULL);
    assign w_gestValid = |gesture_in;
    assign w_pop       = (r_state == ST_IDLE) && !w_empty && !home;
    assign w_push      = w_gestValid && !home && (!w_full || w_pop);
    assign w_drop      = w_gestValid && !home && w_full && !w_pop;
    assign w_head      = r_fifoMem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoMem[r_wrPtr] <= gesture_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            if (home) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + 1'b1;
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    // Clamp each move to the remaining distance so no channel overshoots its target
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            w_posNext[ch] = r_pos[ch];
            w_reached[ch] = (r_pos[ch] == r_target[ch]);
            if (r_pos[ch] < r_target[ch]) begin
                if ((r_target[ch] - r_pos[ch]) > P_STEP) begin
                    w_posNext[ch] = r_pos[ch] + P_STEP;
                end else begin
                    w_posNext[ch] = r_target[ch];
                end
            end else if (r_pos[ch] > r_target[ch]) begin
                if ((r_pos[ch] - r_target[ch]) > P_STEP) begin
                    w_posNext[ch] = r_pos[ch] - P_STEP;
                end else begin
                    w_posNext[ch] = r_target[ch];
                end
            end
        end
    end

    assign w_allReached = &w_reached;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_nextState = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (w_allReached) begin
                    w_nextState = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (r_dwellCnt == DWELL_LAST) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
        if (home) begin
            w_nextState = ST_RAMP;
        end
    end

    // Dwell count is held at zero throughout RAMP so every DWELL starts fresh
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dwellCnt <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_pos[ch]    <= P_OPEN;
                r_target[ch] <= P_OPEN;
            end
        end else begin
            if (r_state == ST_RAMP) begin
                r_dwellCnt <= '0;
            end else if ((r_state == ST_DWELL) && w_tick && (r_dwellCnt != DWELL_LAST)) begin
                r_dwellCnt <= r_dwellCnt + 1'b1;
            end
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (home) begin
                    r_target[ch] <= P_OPEN;
                end else if (w_pop) begin
                    r_target[ch] <= w_head[ch] ? P_CLOSED : P_OPEN;
                end
                if ((r_state == ST_RAMP) && w_tick) begin
                    r_pos[ch] <= w_posNext[ch];
                end
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_posOut
        assign pos_flat[g*POS_W +: POS_W] = r_pos[g];
    end

    assign busy       = (r_state != ST_IDLE);
    assign fifo_count = r_count;
    assign fifo_full  = w_full;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_gesture_sequencer.sv
// Scoreboard bench for gesture_sequencer: expected pose steps and overflow pulses are
// queued as stimulus is issued, and a negedge monitor compares them as the DUT shows them.
module tb_gesture_sequencer;

    localparam int CH     = 8;
    localparam int DEPTH  = 4;
    localparam int PW     = 11;
    localparam int OPEN   = 1000;
    localparam int CLOSED = 2000;
    localparam int STEPV  = 250;
    localparam int TDIV   = 4;
    localparam int DWELLT = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [CH-1:0]    gesture_in;
    logic             home;
    logic [CH*PW-1:0] pos_flat;
    logic             busy;
    logic [2:0]       fifo_count;
    logic             fifo_full;
    logic             overflow;

    int               cmpCount = 0;
    int               errCount = 0;
    int               cycle = 0;
    logic             monEn = 1'b0;
    logic [CH*PW-1:0] prevPos;
    logic [CH*PW-1:0] posQ [$];
    int               ovfQ [$];

    gesture_sequencer #(
        .CHANNELS(CH), .FIFO_DEPTH(DEPTH), .POS_W(PW), .POS_OPEN(OPEN),
        .POS_CLOSED(CLOSED), .STEP(STEPV), .TICK_DIV(TDIV), .DWELL_TICKS(DWELLT)
    ) dut (
        .clk(clk), .reset(reset), .gesture_in(gesture_in), .home(home),
        .pos_flat(pos_flat), .busy(busy), .fifo_count(fifo_count),
        .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Cycle index since the last reset edge; equals the DUT tick counter modulo TDIV
    always @(posedge clk) begin
        if (reset) cycle <= 0;
        else cycle <= cycle + 1;
    end

    function automatic logic [CH*PW-1:0] uniPos(input int v);
        logic [CH*PW-1:0] r;
        for (int i = 0; i < CH; i++) r[i*PW +: PW] = PW'(v);
        return r;
    endfunction

    // Queue the four 250us steps taken when moving from pose fromG to pose toG
    task automatic expectRamp(input logic [CH-1:0] fromG, input logic [CH-1:0] toG);
        logic [CH*PW-1:0] p;
        int v;
        if (fromG == toG) return;
        for (int k = 1; k <= 4; k++) begin
            for (int ch = 0; ch < CH; ch++) begin
                if (fromG[ch] == toG[ch]) v = fromG[ch] ? CLOSED : OPEN;
                else if (toG[ch]) v = OPEN + STEPV * k;
                else v = CLOSED - STEPV * k;
                p[ch*PW +: PW] = PW'(v);
            end
            posQ.push_back(p);
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        cmpCount++;
        if (actual != expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [CH-1:0] g, input logic h);
        gesture_in = g;
        home       = h;
        @(negedge clk);
        gesture_in = '0;
        home       = 1'b0;
    endtask

    task automatic waitIdle(input int maxCyc, input string name);
        int n = 0;
        while (!(busy == 1'b0 && fifo_count == 3'd0) && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        if (!(busy == 1'b0 && fifo_count == 3'd0)) begin
            cmpCount++;
            errCount++;
            $display("[TB] FAIL %s: timeout after %0d cycles, busy=%0b count=%0d", name, n, busy, fifo_count);
        end
    endtask

    task automatic waitBusyLow(input int maxCyc, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            cmpCount++;
            errCount++;
            $display("[TB] FAIL %s: timeout, busy=%0b expected 0", name, busy);
        end
    endtask

    task automatic waitPos(input int v, input int maxCyc, input string name);
        int n = 0;
        while (pos_flat !== uniPos(v) && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        if (pos_flat !== uniPos(v)) begin
            cmpCount++;
            errCount++;
            $display("[TB] FAIL %s: timeout, pos=%h expected all %0d", name, pos_flat, v);
        end
    endtask

    // Monitor: every change of pos_flat and every overflow pulse consumes one expectation
    always @(negedge clk) begin
        logic [CH*PW-1:0] e;
        int eo;
        if (!monEn) begin
            prevPos = pos_flat;
        end else begin
            if (pos_flat !== prevPos) begin
                cmpCount++;
                if (posQ.size() == 0) begin
                    errCount++;
                    $display("[TB] FAIL pos_step: unexpected change to %h", pos_flat);
                end else begin
                    e = posQ.pop_front();
                    if (pos_flat !== e) begin
                        errCount++;
                        $display("[TB] FAIL pos_step: got %h, expected %h", pos_flat, e);
                    end
                end
                prevPos = pos_flat;
            end
            if (overflow === 1'b1) begin
                cmpCount++;
                if (ovfQ.size() == 0) begin
                    errCount++;
                    $display("[TB] FAIL overflow_pulse: unexpected pulse, count=%0d", fifo_count);
                end else begin
                    eo = ovfQ.pop_front();
                    if (int'(fifo_count) != eo) begin
                        errCount++;
                        $display("[TB] FAIL overflow_pulse: count got %0d, expected %0d", fifo_count, eo);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int p;
        int riseCyc;
        int fallCyc;

        reset      = 1'b1;
        gesture_in = '0;
        home       = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        monEn = 1'b1;

        $display("[TB] reset state");
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_count", int'(fifo_count), 0);
        checkOutput("rst_full", int'(fifo_full), 0);
        checkOutput("rst_overflow", int'(overflow), 0);
        for (int i = 0; i < CH; i++)
            checkOutput($sformatf("rst_pos%0d", i), int'(pos_flat[i*PW +: PW]), OPEN);

        $display("[TB] single gesture 8'h01");
        expectRamp(8'h00, 8'h01);
        applyStimulus(8'h01, 1'b0);
        checkOutput("g01_count_after_push", int'(fifo_count), 1);
        checkOutput("g01_busy_before_pop", int'(busy), 0);
        @(negedge clk);
        checkOutput("g01_busy_after_pop", int'(busy), 1);
        checkOutput("g01_count_after_pop", int'(fifo_count), 0);
        waitIdle(200, "g01_done");
        checkOutput("g01_ch0", int'(pos_flat[0 +: PW]), CLOSED);
        checkOutput("g01_ch1", int'(pos_flat[PW +: PW]), OPEN);

        $display("[TB] repeat of current pose");
        for (int n = 0; n < 8 && (cycle % TDIV) != 0; n++) @(negedge clk);
        p = cycle;
        riseCyc = -1;
        fallCyc = -1;
        applyStimulus(8'h01, 1'b0);
        for (int n = 0; n < 40; n++) begin
            if (busy === 1'b1 && riseCyc < 0) riseCyc = cycle;
            if (busy === 1'b0 && riseCyc >= 0) begin
                fallCyc = cycle;
                break;
            end
            @(negedge clk);
        end
        checkOutput("same_pose_busy_rise", riseCyc - p, 2);
        checkOutput("same_pose_busy_fall", fallCyc - p, 9);

        $display("[TB] back-to-back pushes, overflow, simultaneous pop and push");
        expectRamp(8'h01, 8'hFF);
        expectRamp(8'hFF, 8'h0F);
        expectRamp(8'h0F, 8'h01);
        expectRamp(8'h01, 8'h03);
        expectRamp(8'h03, 8'h07);
        ovfQ.push_back(4);
        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'h0F, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'h07, 1'b0);
        checkOutput("fill_count", int'(fifo_count), 4);
        checkOutput("fill_full", int'(fifo_full), 1);
        checkOutput("fill_no_overflow", int'(overflow), 0);
        applyStimulus(8'h80, 1'b0);
        checkOutput("drop_overflow", int'(overflow), 1);
        checkOutput("drop_count", int'(fifo_count), 4);
        @(negedge clk);
        checkOutput("drop_overflow_clear", int'(overflow), 0);
        waitBusyLow(100, "ff_done");
        checkOutput("popush_count_before", int'(fifo_count), 4);
        applyStimulus(8'h07, 1'b0);
        checkOutput("popush_count", int'(fifo_count), 4);
        checkOutput("popush_overflow", int'(overflow), 0);
        checkOutput("popush_busy", int'(busy), 1);
        waitIdle(400, "queue_drain");
        checkOutput("final_ch0", int'(pos_flat[0 +: PW]), CLOSED);
        checkOutput("final_ch2", int'(pos_flat[2*PW +: PW]), CLOSED);
        checkOutput("final_ch3", int'(pos_flat[3*PW +: PW]), OPEN);
        checkOutput("final_ch7", int'(pos_flat[7*PW +: PW]), OPEN);

        $display("[TB] home from idle, then home mid-ramp");
        expectRamp(8'h07, 8'h00);
        applyStimulus(8'h00, 1'b1);
        checkOutput("home_idle_busy", int'(busy), 1);
        waitIdle(200, "home_idle_done");
        posQ.push_back(uniPos(1250));
        posQ.push_back(uniPos(1500));
        posQ.push_back(uniPos(1250));
        posQ.push_back(uniPos(1000));
        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'h0F, 1'b0);
        applyStimulus(8'h03, 1'b0);
        checkOutput("home_queued", int'(fifo_count), 2);
        waitPos(1500, 100, "home_wait_1500");
        applyStimulus(8'h02, 1'b1);
        checkOutput("home_flush_count", int'(fifo_count), 0);
        checkOutput("home_busy", int'(busy), 1);
        waitIdle(200, "home_ramp_done");
        checkOutput("home_end_ch1", int'(pos_flat[PW +: PW]), OPEN);

        $display("[TB] reset mid-ramp");
        posQ.push_back(uniPos(1250));
        posQ.push_back(uniPos(1000));
        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'h0F, 1'b0);
        waitPos(1250, 100, "rst_wait_1250");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midrst_ch0", int'(pos_flat[0 +: PW]), OPEN);
        checkOutput("midrst_ch7", int'(pos_flat[7*PW +: PW]), OPEN);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_count", int'(fifo_count), 0);
        checkOutput("midrst_overflow", int'(overflow), 0);
        repeat (30) @(negedge clk);

        checkOutput("pos_expect_left", posQ.size(), 0);
        checkOutput("ovf_expect_left", ovfQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
